syscall_string_printer: RTL and testbench

- Sequential engine downstream of the writeback stage; services the print-string syscall (v0 == 4).
- On a start pulse it latches the string base address (a0), fetches words from data memory, and streams bytes out over a valid/ready character port until NUL or a length cap.
- Holds the pipeline stall high while printing.

---
 rtl/syscall_string_printer.sv | 123 ++++++++++++
 tb/tb_syscall_string_printer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syscall_string_printer.sv
// Print-string syscall engine: reads a NUL-terminated string from data memory
// word by word and streams its bytes over a valid/ready character port.
module syscall_string_printer #(
    parameter int ADDR_W  = 32,
    parameter int MAX_LEN = 256,
    parameter int CNT_W   = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] string_index,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              char_valid,
    output logic [7:0]        char_data,
    input  logic              char_ready,
    output logic              stall,
    output logic              done,
    output logic              truncated,
    output logic [CNT_W-1:0]  char_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              trunc_q, trunc_d;
    logic [31:0]       word_buf_q;
    logic [7:0]        sel_byte;
    logic [CNT_W-1:0]  count_inc;

    // Big-endian byte lane: offset 0 is the most significant byte.
    always_comb begin
        sel_byte = 8'h00;
        case (addr_q[1:0])
            2'd0: sel_byte = word_buf_q[31:24];
            2'd1: sel_byte = word_buf_q[23:16];
            2'd2: sel_byte = word_buf_q[15:8];
            2'd3: sel_byte = word_buf_q[7:0];
            default: sel_byte = 8'h00;
        endcase
    end

    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        trunc_d = trunc_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = string_index;
                    count_d = '0;
                    trunc_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT:  state_d = S_EMIT;
            S_EMIT: begin
                if (sel_byte == 8'h00) begin
                    state_d = S_DONE;
                end else if (char_ready) begin
                    count_d = count_inc;
                    addr_d  = addr_q + 1'b1;
                    if (count_inc == MAX_CNT) begin
                        trunc_d = 1'b1;
                        state_d = S_DONE;
                    end else if (addr_q[1:0] == 2'd3) begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            trunc_q <= trunc_d;
        end
    end

    // Data-only register: char_data is gated by char_valid, so no reset needed.
    always_ff @(posedge clk) begin
        if (state_q == S_WAIT) begin
            word_buf_q <= mem_rdata;
        end
    end

    always_comb begin
        mem_req    = (state_q == S_FETCH);
        mem_addr   = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        char_valid = (state_q == S_EMIT) && (sel_byte != 8'h00);
        char_data  = char_valid ? sel_byte : 8'h00;
        stall      = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_EMIT);
        done       = (state_q == S_DONE);
        truncated  = trunc_q;
        char_count = count_q;
    end

endmodule

// File: tb/tb_syscall_string_printer.sv
// Bench for syscall_string_printer: directed scenarios plus randomized strings,
// checked against a byte-level reference model of the string walk.
module tb_syscall_string_printer;

    localparam int MAXL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] string_index = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready = 1'b1;
    logic        stall;
    logic        done;
    logic        truncated;
    logic [8:0]  char_count;

    syscall_string_printer #(.ADDR_W(32), .MAX_LEN(MAXL), .CNT_W(9)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .string_index(string_index),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
        .stall(stall), .done(done), .truncated(truncated), .char_count(char_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Byte memory, aliased modulo 1 KiB so wrapped addresses stay in range.
    logic [7:0] mem [0:1023];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [9:0] b;
        b = {a[9:2], 2'b00};
        return {mem[b], mem[b + 10'd1], mem[b + 10'd2], mem[b + 10'd3]};
    endfunction

    always_ff @(posedge clk) begin
        if (mem_req) mem_rdata <= word_at(mem_addr);
    end

    // Ready driver: forced low, random, or always high.
    bit force_low = 0;
    bit rnd_ready = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            char_ready = force_low ? 1'b0 : (rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // Monitor
    logic [7:0]  got_q[$];
    logic [31:0] fetch_q[$];
    int          done_cnt = 0;
    int          cyc = 0;
    int          start_cyc, first_req_cyc, first_val_cyc;
    bit          start_seen;
    bit          hold_prev = 0;
    logic [7:0]  prev_data;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (start && !start_seen) begin
                start_seen = 1;
                start_cyc  = cyc;
            end
            if (mem_req) begin
                fetch_q.push_back(mem_addr);
                if (first_req_cyc < 0) first_req_cyc = cyc;
            end
            if (char_valid && first_val_cyc < 0) first_val_cyc = cyc;
            if (hold_prev) begin
                check("hold_valid", char_valid, 1);
                check("hold_data", char_data, prev_data);
            end
            if (char_valid && char_ready) got_q.push_back(char_data);
            if (mem_req || char_valid) check("stall_busy", stall, 1);
            if (done) begin
                done_cnt++;
                check("stall_done", stall, 0);
            end
            hold_prev = char_valid && !char_ready;
            prev_data = char_data;
        end else begin
            hold_prev = 0;
        end
    end

    // Reference model: walk bytes from the start address until NUL or the cap.
    logic [7:0]  exp_chars[$];
    logic [31:0] exp_fetch[$];
    bit          exp_trunc;

    task automatic model(input logic [31:0] idx);
        logic [31:0] a;
        logic [7:0]  b;
        exp_chars.delete();
        exp_fetch.delete();
        a = idx;
        exp_fetch.push_back({idx[31:2], 2'b00});
        for (int i = 0; i < MAXL; i++) begin
            b = mem[a[9:0]];
            if (b == 8'h00) break;
            exp_chars.push_back(b);
            if (exp_chars.size() == MAXL) break;
            if (a[1:0] == 2'd3) exp_fetch.push_back(a + 32'd1);
            a = a + 32'd1;
        end
        exp_trunc = (exp_chars.size() == MAXL);
    endtask

    task automatic put_word(input logic [31:0] a, input logic [31:0] w);
        mem[a[9:0]]         = w[31:24];
        mem[a[9:0] + 10'd1] = w[23:16];
        mem[a[9:0] + 10'd2] = w[15:8];
        mem[a[9:0] + 10'd3] = w[7:0];
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!char_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!char_valid) check({tag, "_valid_timeout"}, 0, 1);
    endtask

    task automatic run_call(input string tag, input logic [31:0] idx, input bit bp, input bit busy_start);
        int base;
        int n;
        model(idx);
        got_q.delete();
        fetch_q.delete();
        start_seen    = 0;
        first_req_cyc = -1;
        first_val_cyc = -1;
        base          = done_cnt;
        force_low     = bp;
        @(posedge clk);
        #1;
        string_index = idx;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (bp) begin
            @(negedge clk);
            wait_valid(tag);
            for (int i = 0; i < 5; i++) begin
                check({tag, "_bp_valid"}, char_valid, 1);
                check({tag, "_bp_data"}, char_data, exp_chars[0]);
                @(negedge clk);
            end
            force_low = 0;
        end
        if (busy_start) begin
            @(negedge clk);
            wait_valid(tag);
            @(posedge clk);
            #1;
            string_index = idx + 32'd8;
            start        = 1'b1;
            n = 0;
            while (!done && n < 300) begin
                @(negedge clk);
                n++;
            end
            start = 1'b0;
        end
        n = 0;
        while (done_cnt == base && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == base) check({tag, "_done_timeout"}, 0, 1);
        repeat (4) @(negedge clk);
        check({tag, "_done_pulses"}, done_cnt - base, 1);
        check({tag, "_nchars"}, got_q.size(), exp_chars.size());
        for (int i = 0; i < exp_chars.size() && i < got_q.size(); i++)
            check({tag, "_char"}, got_q[i], exp_chars[i]);
        check({tag, "_nfetch"}, fetch_q.size(), exp_fetch.size());
        for (int i = 0; i < exp_fetch.size() && i < fetch_q.size(); i++)
            check({tag, "_fetch"}, fetch_q[i], exp_fetch[i]);
        check({tag, "_count"}, char_count, exp_chars.size());
        check({tag, "_trunc"}, truncated, exp_trunc);
        check({tag, "_req_lat"}, first_req_cyc - start_cyc, 1);
        if (exp_chars.size() > 0) check({tag, "_val_lat"}, first_val_cyc - start_cyc, 3);
        check({tag, "_idle_stall"}, stall, 0);
    endtask

    initial begin
        int base;
        int n;
        logic [31:0] idx;
        int len;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom_range(1, 255));

        #12;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_valid", char_valid, 0);
        check("rst_data", char_data, 0);
        check("rst_stall", stall, 0);
        check("rst_done", done, 0);
        check("rst_trunc", truncated, 0);
        check("rst_count", char_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        put_word(32'h100, 32'h48690000);
        run_call("aligned", 32'h100, 0, 0);

        put_word(32'h140, 32'hFFFF4142);
        put_word(32'h144, 32'h43000000);
        run_call("unaligned", 32'h142, 0, 0);

        run_call("backpressure", 32'h100, 1, 0);

        put_word(32'h200, 32'h41424344);
        put_word(32'h204, 32'h45460000);
        run_call("trunc", 32'h200, 0, 0);

        put_word(32'h180, 32'h00FF1234);
        run_call("empty", 32'h180, 0, 0);

        put_word(32'h1C0, 32'h5A590000);
        put_word(32'h1C8, 32'h31320000);
        rnd_ready = 1;
        run_call("busy_start", 32'h1C0, 0, 1);
        rnd_ready = 0;

        // Reset in the middle of a print.
        put_word(32'h300, 32'h41424300);
        got_q.delete();
        base = done_cnt;
        @(posedge clk);
        #1;
        string_index = 32'h300;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!(got_q.size() >= 1 && char_valid) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("mid_second_valid", char_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", char_valid, 0);
        check("mid_rst_data", char_data, 0);
        check("mid_rst_stall", stall, 0);
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_count", char_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_no_done", done_cnt - base, 0);
        check("mid_idle_stall", stall, 0);
        put_word(32'h120, 32'h4F4B0000);
        run_call("after_reset", 32'h120, 0, 0);

        // Randomized strings, including addresses that wrap past 2^32.
        rnd_ready = 1;
        for (int t = 0; t < 40; t++) begin
            idx = 32'($urandom_range(0, 1000));
            if (t % 8 == 7) idx = 32'hFFFF_FFF0 | 32'($urandom_range(8, 15));
            len = $urandom_range(0, 6);
            for (int k = 0; k < 12; k++) begin
                logic [31:0] a;
                a = {idx[31:2], 2'b00} + 32'(k);
                mem[a[9:0]] = 8'($urandom_range(1, 255));
            end
            idx = idx + 32'd0;
            begin
                logic [31:0] z;
                z = idx + 32'(len);
                mem[z[9:0]] = 8'h00;
            end
            run_call("random", idx, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
